// File: rtl/pawn_move_gen_pkg.sv
// rtl/pawn_move_gen_pkg.sv - shared types and constants for the pawn move generator
//
// Purpose : piece and move-kind enums, square bit layout, side constants,
//           FSM state type and a lowest-set-bit helper for the candidate mask.
// Ports   : none (package).

package pawn_move_gen_pkg;

   typedef enum logic [2:0] {
      PAWN   = 3'd0,
      KNIGHT = 3'd1,
      BISHOP = 3'd2,
      ROOK   = 3'd3,
      QUEEN  = 3'd4,
      KING   = 3'd5
   } piece_t;

   // Square encoding: b0 occupied, b1 colour (1 = black), b4:2 piece type
   localparam int SQ_W       = 5;
   localparam int SQ_OCC     = 0;
   localparam int SQ_COLOR   = 1;
   localparam int SQ_TYPE_LO = 2;
   localparam int SQ_TYPE_HI = 4;

   typedef enum logic [2:0] {
      MK_FWD   = 3'd0,
      MK_DBL   = 3'd1,
      MK_CAP_L = 3'd2,
      MK_CAP_R = 3'd3,
      MK_EP_L  = 3'd4,
      MK_EP_R  = 3'd5
   } move_kind_t;

   localparam logic WHITE = 1'b0;
   localparam logic BLACK = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_EMIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Kind of the lowest set bit; moves are emitted in ascending kind order.
   function automatic move_kind_t lowest_kind(input logic [5:0] m);
      move_kind_t k;
      k = MK_FWD;
      for (int i = 5; i >= 0; i--) begin
         if (m[i]) k = move_kind_t'(i[2:0]);
      end
      return k;
   endfunction

endpackage

// File: rtl/pawn_move_gen_if.sv
// rtl/pawn_move_gen_if.sv - move stream interface of the pawn move generator
//
// Purpose : groups the valid/ready move stream and its payload fields.
// Ports   : move_valid/move_ready handshake; move_from_row/col, move_to_row/col,
//           move_kind, move_promo payload. master = generator, slave = consumer.

interface pawn_move_gen_if #(
   parameter int N_ROWS = 8,
   parameter int N_COLS = 8
);
   localparam int RW = $clog2(N_ROWS);
   localparam int CW = $clog2(N_COLS);

   logic          move_valid;
   logic          move_ready;
   logic [RW-1:0] move_from_row;
   logic [CW-1:0] move_from_col;
   logic [RW-1:0] move_to_row;
   logic [CW-1:0] move_to_col;
   logic [2:0]    move_kind;
   logic          move_promo;

   modport master (
      output move_valid, move_from_row, move_from_col,
             move_to_row, move_to_col, move_kind, move_promo,
      input  move_ready
   );

   modport slave (
      input  move_valid, move_from_row, move_from_col,
             move_to_row, move_to_col, move_kind, move_promo,
      output move_ready
   );
endinterface

// File: rtl/pawn_move_gen_square_eval.sv
// rtl/pawn_move_gen_square_eval.sv - combinational pawn candidate evaluation for one square
//
// Purpose : given the board snapshot, a square, side to move and en passant
//           state, produce the 6-bit candidate mask (bit i = move kind i) and
//           whether the one-step destination row is the promotion rank.
// Ports   : snap (board), row, col, side, ep_valid, ep_col -> mask, promo.

module pawn_square_eval
   import pawn_move_gen_pkg::*;
#(
   parameter int N_ROWS = 8,
   parameter int N_COLS = 8,
   parameter bit DBL_EN = 1'b1,
   parameter bit EP_EN  = 1'b1,
   localparam int RW = $clog2(N_ROWS),
   localparam int CW = $clog2(N_COLS),
   localparam int BW = N_ROWS * N_COLS * SQ_W
) (
   input  logic [BW-1:0] snap,
   input  logic [RW-1:0] row,
   input  logic [CW-1:0] col,
   input  logic          side,
   input  logic          ep_valid,
   input  logic [CW-1:0] ep_col,
   output logic [5:0]    mask,
   output logic          promo
);

   localparam int IW = $clog2(BW);

   // Off-board coordinates read as an empty square, which suppresses every
   // target beyond an edge without any wrap-around.
   function automatic logic [SQ_W-1:0] sq_at(input int rr, input int cc);
      logic [IW-1:0] base;
      logic [SQ_W-1:0] s;
      s    = '0;
      base = '0;
      if (rr >= 0 && rr < N_ROWS && cc >= 0 && cc < N_COLS) begin
         base = IW'((rr * N_COLS + cc) * SQ_W);
         s    = snap[base +: SQ_W];
      end
      return s;
   endfunction

   always_comb begin
      int r, c, d, fr, ec;
      logic [SQ_W-1:0] me, ahead, ahead2, tl, tr, epsq;
      logic own, on_fr, fwd_clear, ep_ok;

      r  = int'(row);
      c  = int'(col);
      ec = int'(ep_col);
      d  = side ? 1 : -1;
      fr = r + d;

      me     = sq_at(r, c);
      ahead  = sq_at(fr, c);
      ahead2 = sq_at(fr + d, c);
      tl     = sq_at(fr, c - 1);
      tr     = sq_at(fr, c + 1);
      epsq   = sq_at(r, ec);

      on_fr     = (fr >= 0) && (fr < N_ROWS);
      own       = me[SQ_OCC] && (me[SQ_COLOR] == side) &&
                  (me[SQ_TYPE_HI:SQ_TYPE_LO] == PAWN);
      fwd_clear = on_fr && !ahead[SQ_OCC];

      ep_ok = EP_EN && own && ep_valid &&
              (r == (side ? N_ROWS - 4 : 3)) &&
              epsq[SQ_OCC] && (epsq[SQ_COLOR] != side) &&
              (epsq[SQ_TYPE_HI:SQ_TYPE_LO] == PAWN);

      mask           = '0;
      mask[MK_FWD]   = own && fwd_clear;
      mask[MK_DBL]   = DBL_EN && own && (r == (side ? 1 : N_ROWS - 2)) &&
                       fwd_clear && !ahead2[SQ_OCC];
      mask[MK_CAP_L] = own && tl[SQ_OCC] && (tl[SQ_COLOR] != side);
      mask[MK_CAP_R] = own && tr[SQ_OCC] && (tr[SQ_COLOR] != side);
      mask[MK_EP_L]  = ep_ok && (c - 1 == ec) && !tl[SQ_OCC];
      mask[MK_EP_R]  = ep_ok && (c + 1 == ec) && !tr[SQ_OCC];

      promo = on_fr && (fr == (side ? N_ROWS - 1 : 0));
   end

endmodule

// File: rtl/pawn_move_gen.sv
// rtl/pawn_move_gen.sv - sequential pawn move generator for one side
//
// Purpose : on start, snapshot the board and scan squares row-major, streaming
//           every pseudo-legal pawn move over a valid/ready stream, then pulse done.
// Ports   : clk, reset (async, active-high); start, side, board, ep_valid,
//           ep_col (sampled with start); busy, done, move_count status;
//           mv (master) carries the move stream.

module pawn_move_gen
   import pawn_move_gen_pkg::*;
#(
   parameter int N_ROWS = 8,
   parameter int N_COLS = 8,
   parameter bit DBL_EN = 1'b1,
   parameter bit EP_EN  = 1'b1,
   localparam int RW = $clog2(N_ROWS),
   localparam int CW = $clog2(N_COLS),
   localparam int BW = N_ROWS * N_COLS * SQ_W
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          side,
   input  logic [BW-1:0] board,
   input  logic          ep_valid,
   input  logic [CW-1:0] ep_col,
   output logic          busy,
   output logic          done,
   output logic [7:0]    move_count,
   pawn_move_gen_if.master mv
);

   state_t        state_q, state_d;
   logic [BW-1:0] snap_q;
   logic          side_q, epv_q;
   logic [CW-1:0] epc_q;
   logic [RW-1:0] row_q;
   logic [CW-1:0] col_q;
   logic [5:0]    mask_q;
   logic [7:0]    count_q;

   logic [5:0]    eval_mask;
   logic          eval_promo;

   pawn_square_eval #(
      .N_ROWS(N_ROWS), .N_COLS(N_COLS), .DBL_EN(DBL_EN), .EP_EN(EP_EN)
   ) u_eval (
      .snap    (snap_q),
      .row     (row_q),
      .col     (col_q),
      .side    (side_q),
      .ep_valid(epv_q),
      .ep_col  (epc_q),
      .mask    (eval_mask),
      .promo   (eval_promo)
   );

   logic          last_sq, hs;
   logic [5:0]    rem_mask, src_mask;
   logic          accept, advance, load;
   move_kind_t    nxt_kind;
   logic [RW-1:0] nxt_to_row, step;
   logic [CW-1:0] nxt_to_col;
   logic          nxt_promo;

   assign last_sq  = (row_q == RW'(N_ROWS - 1)) && (col_q == CW'(N_COLS - 1));
   assign hs       = mv.move_valid && mv.move_ready;
   // Mask with its lowest set bit (the move being presented) removed
   assign rem_mask = mask_q & (mask_q - 6'd1);

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      advance = 1'b0;
      load    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (eval_mask != 6'd0) begin
               load    = 1'b1;
               state_d = ST_EMIT;
            end else if (last_sq) begin
               state_d = ST_DONE;
            end else begin
               advance = 1'b1;
            end
         end
         ST_EMIT: begin
            if (hs) begin
               if (rem_mask != 6'd0) begin
                  load = 1'b1;
               end else if (last_sq) begin
                  state_d = ST_DONE;
               end else begin
                  advance = 1'b1;
                  state_d = ST_SCAN;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Next move fields: from a freshly scanned square or from what remains
   // of the latched mask after the current handshake.
   always_comb begin
      src_mask   = (state_q == ST_SCAN) ? eval_mask : rem_mask;
      nxt_kind   = lowest_kind(src_mask);
      step       = (nxt_kind == MK_DBL) ? RW'(2) : RW'(1);
      nxt_to_row = side_q ? (row_q + step) : (row_q - step);
      case (nxt_kind)
         MK_CAP_L, MK_EP_L: nxt_to_col = col_q - CW'(1);
         MK_CAP_R, MK_EP_R: nxt_to_col = col_q + CW'(1);
         default:           nxt_to_col = col_q;
      endcase
      nxt_promo  = eval_promo &&
                   (nxt_kind == MK_FWD || nxt_kind == MK_CAP_L || nxt_kind == MK_CAP_R);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         snap_q           <= '0;
         side_q           <= 1'b0;
         epv_q            <= 1'b0;
         epc_q            <= '0;
         row_q            <= '0;
         col_q            <= '0;
         mask_q           <= '0;
         count_q          <= '0;
         mv.move_valid    <= 1'b0;
         mv.move_from_row <= '0;
         mv.move_from_col <= '0;
         mv.move_to_row   <= '0;
         mv.move_to_col   <= '0;
         mv.move_kind     <= '0;
         mv.move_promo    <= 1'b0;
      end else begin
         if (accept) begin
            snap_q  <= board;
            side_q  <= side;
            epv_q   <= ep_valid;
            epc_q   <= ep_col;
            row_q   <= '0;
            col_q   <= '0;
            count_q <= '0;
         end
         if (advance) begin
            if (col_q == CW'(N_COLS - 1)) begin
               col_q <= '0;
               row_q <= row_q + RW'(1);
            end else begin
               col_q <= col_q + CW'(1);
            end
         end
         if (state_q == ST_SCAN && eval_mask != 6'd0) mask_q <= eval_mask;
         else if (state_q == ST_EMIT && hs)           mask_q <= rem_mask;
         if (load) begin
            mv.move_valid    <= 1'b1;
            mv.move_from_row <= row_q;
            mv.move_from_col <= col_q;
            mv.move_to_row   <= nxt_to_row;
            mv.move_to_col   <= nxt_to_col;
            mv.move_kind     <= nxt_kind;
            mv.move_promo    <= nxt_promo;
         end else if (hs) begin
            mv.move_valid <= 1'b0;
         end
         if (hs && count_q != 8'hFF) count_q <= count_q + 8'd1;
      end
   end

   assign busy       = (state_q == ST_SCAN) || (state_q == ST_EMIT);
   assign done       = (state_q == ST_DONE);
   assign move_count = count_q;

endmodule

// File: tb/tb_pawn_move_gen.sv
// tb/tb_pawn_move_gen.sv - directed self-checking bench for pawn_move_gen

module tb_pawn_move_gen;

   localparam int NR = 8;
   localparam int NC = 8;

   localparam logic [4:0] W_PAWN = 5'b00001;
   localparam logic [4:0] B_PAWN = 5'b00011;
   localparam logic [4:0] W_KNT  = 5'b00101;
   localparam logic [4:0] B_KNT  = 5'b00111;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic             side;
   logic [NR*NC*5-1:0] board;
   logic             ep_valid;
   logic [2:0]       ep_col;
   logic             busy;
   logic             done;
   logic [7:0]       move_count;

   pawn_move_gen_if #(.N_ROWS(NR), .N_COLS(NC)) mv ();

   pawn_move_gen #(.N_ROWS(NR), .N_COLS(NC), .DBL_EN(1'b1), .EP_EN(1'b1)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .side      (side),
      .board     (board),
      .ep_valid  (ep_valid),
      .ep_col    (ep_col),
      .busy      (busy),
      .done      (done),
      .move_count(move_count),
      .mv        (mv.master)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] got   [0:63];
   logic [15:0] exp_m [0:63];
   int n_got;
   int n_exp;
   int done_cyc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [15:0] cur_pack();
      return {mv.move_from_row, mv.move_from_col, mv.move_to_row,
              mv.move_to_col, mv.move_kind, mv.move_promo};
   endfunction

   task automatic clear_board();
      board = '0;
   endtask

   task automatic put(input int r, input int c, input logic [4:0] v);
      logic [8:0] idx;
      idx = 9'((r * NC + c) * 5);
      board[idx +: 5] = v;
   endtask

   task automatic add_exp(input int fr, input int fc, input int tr, input int tc,
                          input int k, input int p);
      exp_m[n_exp] = {3'(fr), 3'(fc), 3'(tr), 3'(tc), 3'(k), 1'(p)};
      n_exp++;
   endtask

   task automatic init_position();
      clear_board();
      for (int c = 0; c < NC; c++) begin
         put(0, c, B_KNT);
         put(1, c, B_PAWN);
         put(6, c, W_PAWN);
         put(7, c, W_KNT);
      end
   endtask

   task automatic compare_list(input string tag);
      check({tag, "_n"}, 32'(n_got), 32'(n_exp));
      for (int i = 0; i < n_exp; i++) begin
         if (i < n_got) check({tag, "_mv"}, 32'(got[i]), 32'(exp_m[i]));
      end
   endtask

   // One scan: pulse start, accept moves until done. stall_at >= 0 holds ready
   // low for 5 cycles once that many moves were accepted, and pulses start then.
   task automatic run_scan(input logic s, input logic epv, input logic [2:0] epc,
                           input int stall_at);
      int cyc;
      int stalled;
      logic fin;
      logic [15:0] held;
      n_got = 0; fin = 1'b0; cyc = 0; stalled = 0; done_cyc = -1; held = '0;
      @(negedge clk);
      side = s; ep_valid = epv; ep_col = epc; start = 1'b1; mv.move_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
      while (!fin && cyc < 3000) begin
         if (stall_at >= 0 && n_got == stall_at && stalled < 5 && mv.move_valid) begin
            mv.move_ready = 1'b0;
            start = (stalled == 2);
            if (stalled == 0) held = cur_pack();
            else check("stall_hold", 32'(cur_pack()), 32'(held));
            stalled++;
         end else begin
            mv.move_ready = 1'b1;
            start = 1'b0;
            if (done) begin
               fin = 1'b1;
               done_cyc = cyc;
               check("busy_at_done", 32'(busy), 32'd0);
            end else if (mv.move_valid) begin
               if (n_got < 64) got[n_got] = cur_pack();
               n_got++;
            end
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check("done_seen", 32'(fin), 32'd1);
      check("done_one_cycle", 32'(done), 32'd0);
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (!mv.move_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(mv.move_valid), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed no finish, expected finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; start = 1'b0; side = 1'b0; ep_valid = 1'b0; ep_col = '0;
      board = '0; mv.move_ready = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_valid", 32'(mv.move_valid), 32'd0);
      check("rst_busy",  32'(busy), 32'd0);
      check("rst_done",  32'(done), 32'd0);
      check("rst_count", 32'(move_count), 32'd0);
      check("rst_fields", 32'(cur_pack()), 32'd0);

      // Empty board: done after N_ROWS*N_COLS+1 cycles, no moves
      clear_board();
      n_exp = 0;
      run_scan(1'b0, 1'b0, 3'd0, -1);
      check("empty_done_cycle", 32'(done_cyc), 32'(NR * NC));
      compare_list("empty");
      check("empty_count", 32'(move_count), 32'd0);

      // Initial position, white: FWD then DBL for each file
      init_position();
      n_exp = 0;
      for (int c = 0; c < NC; c++) begin
         add_exp(6, c, 5, c, 0, 0);
         add_exp(6, c, 4, c, 1, 0);
      end
      run_scan(1'b0, 1'b0, 3'd0, -1);
      compare_list("init");
      check("init_count", 32'(move_count), 32'd16);

      // Promotion with captures on both sides
      clear_board();
      put(1, 3, W_PAWN); put(0, 2, B_KNT); put(0, 4, B_KNT);
      n_exp = 0;
      add_exp(1, 3, 0, 3, 0, 1);
      add_exp(1, 3, 0, 2, 2, 1);
      add_exp(1, 3, 0, 4, 3, 1);
      run_scan(1'b0, 1'b0, 3'd0, -1);
      compare_list("promo");
      check("promo_count", 32'(move_count), 32'd3);

      // En passant to the right, then without ep_valid
      clear_board();
      put(3, 4, W_PAWN); put(3, 5, B_PAWN);
      n_exp = 0;
      add_exp(3, 4, 2, 4, 0, 0);
      add_exp(3, 4, 2, 5, 5, 0);
      run_scan(1'b0, 1'b1, 3'd5, -1);
      compare_list("ep_on");
      n_exp = 0;
      add_exp(3, 4, 2, 4, 0, 0);
      run_scan(1'b0, 1'b0, 3'd5, -1);
      compare_list("ep_off");
      check("ep_off_count", 32'(move_count), 32'd1);

      // Black pawn on the right edge
      clear_board();
      put(1, 7, B_PAWN); put(2, 6, W_PAWN);
      n_exp = 0;
      add_exp(1, 7, 2, 7, 0, 0);
      add_exp(1, 7, 3, 7, 1, 0);
      add_exp(1, 7, 2, 6, 2, 0);
      run_scan(1'b1, 1'b0, 3'd0, -1);
      compare_list("black_edge");
      check("black_edge_count", 32'(move_count), 32'd3);

      // Backpressure mid-stream plus an ignored start while busy
      init_position();
      n_exp = 0;
      for (int c = 0; c < NC; c++) begin
         add_exp(6, c, 5, c, 0, 0);
         add_exp(6, c, 4, c, 1, 0);
      end
      run_scan(1'b0, 1'b0, 3'd0, 3);
      compare_list("bp");
      check("bp_count", 32'(move_count), 32'd16);
      repeat (3) @(negedge clk);
      check("bp_idle_after", 32'(busy), 32'd0);
      check("bp_count_hold", 32'(move_count), 32'd16);

      // Reset during EMIT, then a fresh scan from (0,0)
      init_position();
      @(negedge clk);
      side = 1'b0; ep_valid = 1'b0; start = 1'b1; mv.move_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      wait_valid("pre_reset_valid1");
      mv.move_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      mv.move_ready = 1'b0;
      wait_valid("pre_reset_valid2");
      check("pre_reset_count", 32'(move_count), 32'd2);
      check("pre_reset_move", 32'(cur_pack()), {16'd0, 3'd6, 3'd1, 3'd5, 3'd1, 3'd0, 1'b0});
      reset = 1'b1;
      #1;
      check("arst_valid", 32'(mv.move_valid), 32'd0);
      @(negedge clk);
      check("arst_busy",  32'(busy), 32'd0);
      check("arst_count", 32'(move_count), 32'd0);
      reset = 1'b0;
      n_exp = 0;
      for (int c = 0; c < NC; c++) begin
         add_exp(6, c, 5, c, 0, 0);
         add_exp(6, c, 4, c, 1, 0);
      end
      run_scan(1'b0, 1'b0, 3'd0, -1);
      compare_list("post_reset");
      check("post_reset_count", 32'(move_count), 32'd16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
